// File: rtl/tpu_pkg.sv
// Shared types for the TPU activation datapath.
//   DATA_W     : width of one signed fixed-point activation
//   act_t      : one signed activation
//   row_word_t : one packed row word {col2, col1}
//   wb_state_t : writeback FSM state
package tpu_pkg;
  localparam int DATA_W = 16;

  typedef logic signed [DATA_W-1:0] act_t;
  typedef logic [2*DATA_W-1:0]      row_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } wb_state_t;
endpackage

// File: rtl/wb_row_fifo.sv
// Small synchronous FIFO for packed row words, fall-through head.
//   clk, rst      : clock, synchronous active-high reset
//   push, din     : write one entry (ignored when full unless popping)
//   pop           : remove head (ignored when empty)
//   dout          : current head, valid while !empty
//   full, empty   : occupancy flags
module wb_row_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/activation_writeback.sv
// Writeback stage behind the two-column leaky-ReLU block. Realigns the
// skewed column streams (col2 trails col1 by one cycle) into {col2, col1}
// row words, buffers them, and issues sequentially addressed writes to the
// unified buffer with valid/ready. Pulses done once all rows are written.
// Optional build macro: WB_SKEW_CHECK_EN enables the sticky skew error flag.
//   clk, rst                 : clock, synchronous active-high reset
//   wb_start_in              : pulse; latches base address / row count (IDLE only)
//   wb_base_addr_in          : first write address
//   wb_num_rows_in           : number of row words
//   wb_valid_1/2_in, data    : per-column activation streams
//   ub_wr_valid/addr/data_out, ub_wr_ready_in : write request handshake
//   wb_busy_out              : high while RUN
//   wb_done_out              : one-cycle completion pulse
//   wb_overflow_out          : sticky, a row was dropped on a full FIFO
//   wb_skew_err_out          : sticky skew violation (0 unless WB_SKEW_CHECK_EN)
module activation_writeback #(
  parameter int DATA_W     = tpu_pkg::DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_start_in,
  input  logic [ADDR_W-1:0]   wb_base_addr_in,
  input  logic [ADDR_W-1:0]   wb_num_rows_in,
  input  logic                wb_valid_1_in,
  input  logic                wb_valid_2_in,
  input  logic [DATA_W-1:0]   wb_data_1_in,
  input  logic [DATA_W-1:0]   wb_data_2_in,
  output logic                ub_wr_valid_out,
  input  logic                ub_wr_ready_in,
  output logic [ADDR_W-1:0]   ub_wr_addr_out,
  output logic [2*DATA_W-1:0] ub_wr_data_out,
  output logic                wb_busy_out,
  output logic                wb_done_out,
  output logic                wb_overflow_out,
  output logic                wb_skew_err_out
);
  import tpu_pkg::*;

  localparam int WORD_W = 2*DATA_W;

  wb_state_t          state;
  logic [ADDR_W-1:0]  base_q, rows_q, pushed_q, written_q;
  logic [DATA_W-1:0]  hold_q;
  logic               hold_full;
  logic               ovf_q;

  logic               start_ok, pair, want_push, fifo_push, fifo_pop, drop_ovf;
  logic               fifo_full, fifo_empty;
  logic [WORD_W-1:0]  pair_word, fifo_head;

  assign start_ok  = wb_start_in & (state == IDLE);

  // Deskew: col2 pairs with the col1 value captured on an earlier cycle.
  assign pair      = wb_valid_2_in & hold_full;
  assign pair_word = {wb_data_2_in, hold_q};

  assign fifo_pop  = ~fifo_empty & ub_wr_ready_in;
  assign want_push = pair & (state == RUN) & (pushed_q < rows_q);
  assign fifo_push = want_push & (~fifo_full | fifo_pop);
  assign drop_ovf  = want_push & fifo_full & ~fifo_pop;

  wb_row_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (pair_word),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Hold register: a new col1 always loads; a pair alone empties it. When
  // both arrive together the pair consumed the old value, so it stays full.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q    <= '0;
      hold_full <= 1'b0;
    end else if (wb_valid_1_in) begin
      hold_q    <= wb_data_1_in;
      hold_full <= 1'b1;
    end else if (pair) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      base_q    <= '0;
      rows_q    <= '0;
      pushed_q  <= '0;
      written_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (wb_start_in)
                state <= (wb_num_rows_in == '0) ? DONE : RUN;
        RUN:  if (written_q == rows_q) state <= DONE;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase

      if (start_ok) begin
        base_q    <= wb_base_addr_in;
        rows_q    <= wb_num_rows_in;
        pushed_q  <= '0;
        written_q <= '0;
        ovf_q     <= 1'b0;
      end else begin
        if (fifo_push) pushed_q  <= pushed_q + 1'b1;
        if (fifo_pop)  written_q <= written_q + 1'b1;
        if (drop_ovf)  ovf_q     <= 1'b1;
      end
    end
  end

`ifdef WB_SKEW_CHECK_EN
  logic skew_q;
  always_ff @(posedge clk) begin
    if (rst || start_ok)
      skew_q <= 1'b0;
    else if ((wb_valid_2_in & ~hold_full) |
             (wb_valid_1_in & hold_full & ~wb_valid_2_in))
      skew_q <= 1'b1;
  end
  assign wb_skew_err_out = skew_q;
`else
  assign wb_skew_err_out = 1'b0;
`endif

  assign ub_wr_valid_out = ~fifo_empty;
  assign ub_wr_addr_out  = base_q + written_q;
  // FIFO storage is not reset; mask so the idle bus reads zero.
  assign ub_wr_data_out  = fifo_empty ? '0 : fifo_head;
  assign wb_busy_out     = (state == RUN);
  assign wb_done_out     = (state == DONE);
  assign wb_overflow_out = ovf_q;
endmodule
